path_delay_meter: RTL and testbench
===================================

Name: path_delay_meter

Overview:
Launch/capture controller that drives the input of an inverter-chain delay path and times its output.
- Toggles pathInput once per trial and counts clock cycles until the synchronized pathResult reaches the expected level.
- Accumulates last/min/max/sum statistics over a programmed number of trials.
- Sits directly upstream (driver) and downstream (sampler) of a chained path instance inside the delay-spy sensor.

Parameters:
CNT_W, 16, width of per-trial cycle counter and min/max/last outputs
TRIAL_W, 8, width of trial count
INVERTING, 0, net polarity of attached chain (1 = odd number of inverting stages)
SETTLE_CYC, 8, cycles pathInput is held stable after each capture before next launch (>=1)
TIMEOUT, 1023, maximum count in WAIT before abort (< 2**CNT_W)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  begin run; sampled only in IDLE
numTrials  input  TRIAL_W  trials per run; latched on accepted start
pathInput  output  1  drive to chain input (registered)
pathResult  input  1  chain output (asynchronous to clk)
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at end of run
timeoutErr  output  1  sticky; set on timeout, cleared on next accepted start
trialsDone  output  TRIAL_W  completed trials in current/last run
lastCount  output  CNT_W  count of most recent trial
minCount  output  CNT_W  minimum count this run
maxCount  output  CNT_W  maximum count this run
sumCount  output  CNT_W+TRIAL_W  sum of counts this run

Behaviour:
- Clocking and reset: one clock, synchronous active-high rst. On reset: state IDLE, pathInput=0, busy=0, done=0, timeoutErr=0, trialsDone=0, lastCount=0, minCount=all-ones, maxCount=0, sumCount=0, sync flops=0.
- Reset mid-run aborts immediately to the reset values.
- Synchronizer: pathResult passes through 2 flops (s1, s2); all decisions use s2. expected = pathInput XOR INVERTING.
- FSM states: IDLE, SETTLE, LAUNCH, WAIT, DONE.
- IDLE: start=1 latches numTrials and clears stats to reset values (timeoutErr, trialsDone too); busy=1. If numTrials=0 go to DONE, otherwise go to SETTLE with settle counter=0.
- SETTLE: hold pathInput; increment settle counter; after SETTLE_CYC cycles go to LAUNCH.
- LAUNCH (1 cycle): pathInput <= ~pathInput; count <= 0; go to WAIT. Polarity alternates between trials; no return-to-zero.
- WAIT: each cycle with s2 != expected, count++.
  - First cycle with s2 == expected: lastCount <= count; min/max updated; sumCount += count; trialsDone++. Then go to DONE if trialsDone+1 == numTrials, else go to SETTLE.
  - If count reaches TIMEOUT with s2 != expected: timeoutErr <= 1; go to DONE. The aborted trial is not recorded.
- DONE (1 cycle): done=1, busy <= 0, go to IDLE. Stats hold until next accepted start.
- Latency calibration: zero-delay loopback (pathResult=pathInput, INVERTING=0) yields count=2, i.e. the synchronizer depth. Each extra cycle of path delay adds 1.
- start while busy is ignored. start held high re-triggers on the cycle after DONE.
- sumCount is wide enough for 2**TRIAL_W-1 maximum counts; no saturation is needed.

Optional Feature:
Macro DELAY_METER_GLITCH_EN.
- Defined: adds output glitchCount (16 bits), cleared on accepted start. It increments (saturating at 0xFFFF) on every s2 transition observed while in SETTLE, where the path must be stable, and on every s2 transition in WAIT after the first within a trial.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Loopback pathResult=pathInput, INVERTING=0, numTrials=4 -> lastCount=min=max=2, sumCount=8, trialsDone=4, done pulses once, pathInput ends at 0.
- Bench model of 5 registered delay stages with INVERTING=1 (inverted loopback), numTrials=3 -> every count=7, sumCount=21, timeoutErr=0.
- Model alternating 3/6-cycle delays, numTrials=4 -> min=5, max=8, sum=26.
- pathResult tied constant so expected is never met, TIMEOUT=1023 -> timeoutErr=1 after 1023 WAIT cycles, done pulses, trialsDone=0; next start clears timeoutErr.
- numTrials=0 -> done pulses 2 cycles after start, pathInput never toggles, stats at reset values.
- Assert rst during WAIT of trial 2 -> next cycle: all outputs at reset values, state IDLE; start pulses asserted during busy are ignored (checked in a separate run).

Source files
------------

// File: rtl/path_delay_meter.sv
// path_delay_meter: toggles a delay chain's input once per trial and times the synchronized return (optional glitch counter: DELAY_METER_GLITCH_EN).
// Latency: zero-delay loopback measures 2 cycles (synchronizer depth); done pulses the cycle after the DONE state.
// Backpressure: none; start is accepted only in IDLE and ignored while busy.
module path_delay_meter #(
    parameter int CNT_W      = 16,
    parameter int TRIAL_W    = 8,
    parameter int INVERTING  = 0,
    parameter int SETTLE_CYC = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [TRIAL_W-1:0]       numTrials,
    output logic                     pathInput,
    input  logic                     pathResult,
    output logic                     busy,
    output logic                     done,
    output logic                     timeoutErr,
`ifdef DELAY_METER_GLITCH_EN
    output logic [15:0]              glitchCount,
`endif
    output logic [TRIAL_W-1:0]       trialsDone,
    output logic [CNT_W-1:0]         lastCount,
    output logic [CNT_W-1:0]         minCount,
    output logic [CNT_W-1:0]         maxCount,
    output logic [CNT_W+TRIAL_W-1:0] sumCount
);

    localparam int SUM_W = CNT_W + TRIAL_W;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);
    localparam logic             INV_L    = (INVERTING != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q;
    logic               pin_q, pin_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               terr_q, terr_d;
    logic [TRIAL_W-1:0] ntr_q, ntr_d;
    logic [TRIAL_W-1:0] trials_q, trials_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [CNT_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   min_q, min_d;
    logic [CNT_W-1:0]   max_q, max_d;
    logic [SUM_W-1:0]   sum_q, sum_d;

    logic               match;
    logic [CNT_W-1:0]   count_inc;
    logic [TRIAL_W-1:0] trials_inc;

`ifdef DELAY_METER_GLITCH_EN
    logic               s3_q;
    logic               seen_q, seen_d;
    logic [15:0]        glitch_q, glitch_d;
    logic               s2_edge;
    logic [15:0]        glitch_inc;

    assign s2_edge    = s2_q ^ s3_q;
    assign glitch_inc = (glitch_q == 16'hFFFF) ? glitch_q : glitch_q + 16'd1;
`endif

    assign match      = (s2_q == (pin_q ^ INV_L));
    assign count_inc  = count_q + CNT_W'(1);
    assign trials_inc = trials_q + TRIAL_W'(1);

    always_comb begin
        state_d  = state_q;
        pin_d    = pin_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        terr_d   = terr_q;
        ntr_d    = ntr_q;
        trials_d = trials_q;
        count_d  = count_q;
        settle_d = settle_q;
        last_d   = last_q;
        min_d    = min_q;
        max_d    = max_q;
        sum_d    = sum_q;
`ifdef DELAY_METER_GLITCH_EN
        seen_d   = seen_q;
        glitch_d = glitch_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ntr_d    = numTrials;
                    terr_d   = 1'b0;
                    trials_d = '0;
                    last_d   = '0;
                    min_d    = '1;
                    max_d    = '0;
                    sum_d    = '0;
                    busy_d   = 1'b1;
                    settle_d = '0;
`ifdef DELAY_METER_GLITCH_EN
                    glitch_d = '0;
`endif
                    state_d  = (numTrials == '0) ? S_DONE : S_SETTLE;
                end
            end
            S_SETTLE: begin
`ifdef DELAY_METER_GLITCH_EN
                // The path should be quiet here; any movement is a glitch.
                if (s2_edge) glitch_d = glitch_inc;
`endif
                if (settle_q == SET_LAST) begin
                    state_d = S_LAUNCH;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_LAUNCH: begin
                pin_d   = ~pin_q;
                count_d = '0;
`ifdef DELAY_METER_GLITCH_EN
                seen_d  = 1'b0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef DELAY_METER_GLITCH_EN
                if (s2_edge) begin
                    if (seen_q) glitch_d = glitch_inc;
                    else        seen_d   = 1'b1;
                end
`endif
                if (match) begin
                    last_d   = count_q;
                    if (count_q < min_q) min_d = count_q;
                    if (count_q > max_q) max_d = count_q;
                    sum_d    = sum_q + {{TRIAL_W{1'b0}}, count_q};
                    trials_d = trials_inc;
                    settle_d = '0;
                    state_d  = (trials_inc == ntr_q) ? S_DONE : S_SETTLE;
                end else if (count_inc == TO_CNT) begin
                    // Aborted trial leaves the statistics untouched.
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    count_d = count_inc;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            pin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
            ntr_q    <= '0;
            trials_q <= '0;
            count_q  <= '0;
            settle_q <= '0;
            last_q   <= '0;
            min_q    <= '1;
            max_q    <= '0;
            sum_q    <= '0;
`ifdef DELAY_METER_GLITCH_EN
            s3_q     <= 1'b0;
            seen_q   <= 1'b0;
            glitch_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            s1_q     <= pathResult;
            s2_q     <= s1_q;
            pin_q    <= pin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
            ntr_q    <= ntr_d;
            trials_q <= trials_d;
            count_q  <= count_d;
            settle_q <= settle_d;
            last_q   <= last_d;
            min_q    <= min_d;
            max_q    <= max_d;
            sum_q    <= sum_d;
`ifdef DELAY_METER_GLITCH_EN
            s3_q     <= s2_q;
            seen_q   <= seen_d;
            glitch_q <= glitch_d;
`endif
        end
    end

    assign pathInput  = pin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeoutErr = terr_q;
    assign trialsDone = trials_q;
    assign lastCount  = last_q;
    assign minCount   = min_q;
    assign maxCount   = max_q;
    assign sumCount   = sum_q;
`ifdef DELAY_METER_GLITCH_EN
    assign glitchCount = glitch_q;
`endif

endmodule

// File: tb/tb_path_delay_meter.sv
// Bench for path_delay_meter: loopback, registered-chain and timeout path models around two instances.
module tb_path_delay_meter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start0, start1;
    logic [7:0] nt0, nt1;
    logic       pi0, pi1, pr0, pr1;
    logic       busy0, busy1, done0, done1, terr0, terr1;
    logic [7:0] td0, td1;
    logic [15:0] last0, last1, min0, min1, max0, max1;
    logic [23:0] sum0, sum1;
`ifdef DELAY_METER_GLITCH_EN
    logic [15:0] gl0, gl1;
`endif

    path_delay_meter #(.INVERTING(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .numTrials(nt0),
        .pathInput(pi0), .pathResult(pr0), .busy(busy0), .done(done0),
        .timeoutErr(terr0),
`ifdef DELAY_METER_GLITCH_EN
        .glitchCount(gl0),
`endif
        .trialsDone(td0), .lastCount(last0), .minCount(min0),
        .maxCount(max0), .sumCount(sum0)
    );

    path_delay_meter #(.INVERTING(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .numTrials(nt1),
        .pathInput(pi1), .pathResult(pr1), .busy(busy1), .done(done1),
        .timeoutErr(terr1),
`ifdef DELAY_METER_GLITCH_EN
        .glitchCount(gl1),
`endif
        .trialsDone(td1), .lastCount(last1), .minCount(min1),
        .maxCount(max1), .sumCount(sum1)
    );

    // Path models: mode 0 loopback, 1 alternating 3/6-cycle delay, 2 stuck at 0.
    int         mode = 0;
    logic [5:0] d0;
    logic [4:0] d1;
    always_ff @(posedge clk) begin
        if (rst) begin
            d0 <= '0;
            d1 <= '0;
        end else begin
            d0 <= {d0[4:0], pi0};
            d1 <= {d1[3:0], pi1};
        end
    end
    always_comb begin
        case (mode)
            0:       pr0 = pi0;
            1:       pr0 = pi0 ? d0[2] : d0[5];
            default: pr0 = 1'b0;
        endcase
    end
    assign pr1 = ~d1[4];

    typedef struct packed {
        logic        pi;
        logic        busy;
        logic        done;
        logic        terr;
        logic [7:0]  td;
        logic [15:0] last;
        logic [15:0] min;
        logic [15:0] max;
        logic [23:0] sum;
    } obs_t;

    obs_t obs0, obs1;
    assign obs0 = {pi0, busy0, done0, terr0, td0, last0, min0, max0, sum0};
    assign obs1 = {pi1, busy1, done1, terr1, td1, last1, min1, max1, sum1};

    function automatic obs_t get_obs(input int sel);
        return (sel == 1) ? obs1 : obs0;
    endfunction

    // Cycles from the latest pathInput toggle to the rising edge of timeoutErr.
    int   since0 = 0;
    int   to_lat = -1;
    logic pi_prev = 1'b0;
    logic to_prev = 1'b0;
    always @(negedge clk) begin
        since0  <= (pi0 !== pi_prev) ? 0 : since0 + 1;
        pi_prev <= pi0;
        to_prev <= terr0;
        if (terr0 && !to_prev) to_lat <= (pi0 !== pi_prev) ? 0 : since0 + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pi"},   pi0,   1'b0);
        check({tag, "_busy"}, busy0, 1'b0);
        check({tag, "_done"}, done0, 1'b0);
        check({tag, "_terr"}, terr0, 1'b0);
        check({tag, "_td"},   td0,   8'd0);
        check({tag, "_last"}, last0, 16'd0);
        check({tag, "_min"},  min0,  16'hFFFF);
        check({tag, "_max"},  max0,  16'd0);
        check({tag, "_sum"},  sum0,  24'd0);
    endtask

    typedef struct {
        int          sel;
        int          mode;
        logic [7:0]  n;
        logic [15:0] e_last;
        logic [15:0] e_min;
        logic [15:0] e_max;
        logic [23:0] e_sum;
        logic [7:0]  e_td;
        logic        e_to;
        logic        e_pi;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input int idx);
        vec_t  v;
        obs_t  o;
        int    dones;
        bit    got;
        string t;
        v = vecs[idx];
        t = $sformatf("v%0d", idx);
        mode = v.mode;
        repeat (4) @(negedge clk);
        if (v.sel == 0) begin start0 = 1'b1; nt0 = v.n; end
        else            begin start1 = 1'b1; nt1 = v.n; end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        got   = 1'b0;
        dones = 0;
        for (int c = 0; c < 6000 && !got; c++) begin
            o = get_obs(v.sel);
            if (o.done) begin got = 1'b1; dones = 1; end
            else @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            o = get_obs(v.sel);
            if (o.done) dones++;
        end
        check({t, "_done_seen"},  got,    1'b1);
        check({t, "_done_count"}, dones,  1);
        check({t, "_busy"},       o.busy, 1'b0);
        check({t, "_last"},       o.last, v.e_last);
        check({t, "_min"},        o.min,  v.e_min);
        check({t, "_max"},        o.max,  v.e_max);
        check({t, "_sum"},        o.sum,  v.e_sum);
        check({t, "_trials"},     o.td,   v.e_td);
        check({t, "_timeout"},    o.terr, v.e_to);
        check({t, "_pathin"},     o.pi,   v.e_pi);
`ifdef DELAY_METER_GLITCH_EN
        check({t, "_glitch"}, (v.sel == 1) ? gl1 : gl0, 16'd0);
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dones;
        int   busy_after;
        bit   got;
        logic pi_before;

        //          sel mode n      last    min       max     sum      td    to    pi
        vecs[0] = '{0, 0, 8'd4,   16'd2, 16'd2,    16'd2, 24'd8,   8'd4,   1'b0, 1'b0};
        vecs[1] = '{0, 0, 8'd255, 16'd2, 16'd2,    16'd2, 24'd510, 8'd255, 1'b0, 1'b1};
        vecs[2] = '{0, 0, 8'd1,   16'd2, 16'd2,    16'd2, 24'd2,   8'd1,   1'b0, 1'b0};
        vecs[3] = '{0, 1, 8'd4,   16'd8, 16'd5,    16'd8, 24'd26,  8'd4,   1'b0, 1'b0};
        vecs[4] = '{1, 1, 8'd3,   16'd7, 16'd7,    16'd7, 24'd21,  8'd3,   1'b0, 1'b1};
        vecs[5] = '{0, 2, 8'd2,   16'd0, 16'hFFFF, 16'd0, 24'd0,   8'd0,   1'b1, 1'b1};
        vecs[6] = '{0, 0, 8'd0,   16'd0, 16'hFFFF, 16'd0, 24'd0,   8'd0,   1'b0, 1'b1};
        vecs[7] = '{0, 0, 8'd3,   16'd2, 16'd2,    16'd2, 24'd6,   8'd3,   1'b0, 1'b0};
        vecs[8] = '{0, 0, 8'd1,   16'd2, 16'd2,    16'd2, 24'd2,   8'd1,   1'b1 ^ 1'b1, 1'b1};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; nt0 = '0; nt1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        for (int i = 0; i < 8; i++) run_vec(i);
        check("timeout_latency", to_lat, 1023);

        // numTrials=0: done two cycles after start, pathInput untouched.
        mode = 0;
        pi_before = pi0;
        @(negedge clk);
        start0 = 1'b1; nt0 = 8'd0;
        @(negedge clk);
        start0 = 1'b0;
        check("n0_busy_c1", busy0, 1'b1);
        check("n0_done_c1", done0, 1'b0);
        @(negedge clk);
        check("n0_done_c2", done0, 1'b1);
        check("n0_busy_c2", busy0, 1'b0);
        @(negedge clk);
        check("n0_done_c3", done0, 1'b0);
        check("n0_pathin",  pi0,   pi_before);

        // Reset during the WAIT of trial 2.
        mode = 0;
        @(negedge clk);
        start0 = 1'b1; nt0 = 8'd4;
        @(negedge clk);
        start0 = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (td0 == 8'd1 && pi0 == 1'b0) got = 1'b1;
            else @(negedge clk);
        end
        check("rst_reach_trial2", got, 1'b1);
        check("rst_pre_busy", busy0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        run_vec(8);

        // start pulses while busy must not retrigger.
        mode = 0;
        @(negedge clk);
        start0 = 1'b1; nt0 = 8'd2;
        @(negedge clk);
        start0 = 1'b0;
        dones = 0;
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            if (done0) begin
                got = 1'b1;
                dones++;
                start0 = 1'b0;
            end else begin
                start0 = (busy0 && (c % 3 == 0)) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
        end
        start0 = 1'b0;
        busy_after = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy0) busy_after++;
            if (done0) dones++;
        end
        check("busy_start_done_seen", got, 1'b1);
        check("busy_start_dones", dones, 1);
        check("busy_start_no_retrig", busy_after, 0);
        check("busy_start_trials", td0, 8'd2);
        check("busy_start_sum", sum0, 24'd4);
        check("busy_start_pathin", pi0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
